// File: rtl/dmem_sramlike_bridge.sv
// dmem_sramlike_bridge: turns the MIPS M-stage single-cycle data port into a
// split-transaction sram-like bus (req/addr_ok/data_ok), one access in flight,
// stalling the M stage until the access has completed.
// Optional build macro: DMEM_KSEG_MAP_EN (kseg0/kseg1 -> physical address map).
module dmem_sramlike_bridge #(
  parameter int ADDR_W    = 32,
  parameter int LAT_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_en_i,
  input  logic [3:0]           mem_wen_i,
  input  logic [1:0]           mem_size_i,
  input  logic [ADDR_W-1:0]    mem_addr_i,
  input  logic [31:0]          mem_wdata_i,
  output logic [31:0]          mem_rdata_o,
  output logic                 mem_stall_o,
  input  logic                 cpu_stall_i,
  input  logic                 flush_i,
  output logic                 data_req,
  output logic                 data_wr,
  output logic [1:0]           data_size,
  output logic [ADDR_W-1:0]    data_addr,
  output logic [31:0]          data_wdata,
  input  logic                 data_addr_ok,
  input  logic [31:0]          data_rdata,
  input  logic                 data_data_ok,
  output logic [LAT_CNT_W-1:0] last_lat_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e                state_q, state_d;
  logic                  wr_q, wr_d;
  logic [1:0]            size_q, size_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  kill_q, kill_d;
  logic [LAT_CNT_W-1:0]  lat_q, lat_d;
  logic [LAT_CNT_W-1:0]  last_lat_q, last_lat_d;

  logic                  go;
  logic                  kill;
  logic [LAT_CNT_W-1:0]  lat_inc;

  assign go      = mem_en_i & ~flush_i;
  // A flush seen at any point while on the bus cancels the result delivery.
  assign kill    = kill_q | flush_i;
  assign lat_inc = (&lat_q) ? lat_q : lat_q + 1'b1;

  // Next-state, bus request and stall decode.
  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    size_d      = size_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    kill_d      = kill_q;
    lat_d       = lat_q;
    last_lat_d  = last_lat_q;
    data_req    = 1'b0;
    mem_stall_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (go) begin
          wr_d        = |mem_wen_i;
          size_d      = mem_size_i;
          addr_d      = mem_addr_i;
          wdata_d     = mem_wdata_i;
          kill_d      = 1'b0;
          lat_d       = '0;
          mem_stall_o = 1'b1;
          state_d     = REQ;
        end
      end
      REQ: begin
        // Request stays up even when flushed: sram-like reqs cannot be withdrawn.
        data_req    = 1'b1;
        mem_stall_o = 1'b1;
        lat_d       = lat_inc;
        kill_d      = kill;
        if (data_addr_ok) begin
          if (data_data_ok) begin
            last_lat_d = lat_q;
            if (!kill && !wr_q) rdata_d = data_rdata;
            state_d = kill ? IDLE : DONE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        mem_stall_o = ~data_data_ok;
        lat_d       = lat_inc;
        kill_d      = kill;
        if (data_data_ok) begin
          last_lat_d = lat_q;
          if (!kill && !wr_q) rdata_d = data_rdata;
          state_d = kill ? IDLE : DONE;
        end
      end
      DONE: begin
        // Hold here while the core is frozen so the same instruction is not re-issued.
        if (!cpu_stall_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latched transaction registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_q       <= 1'b0;
      size_q     <= 2'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      kill_q     <= 1'b0;
      lat_q      <= '0;
      last_lat_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      size_q     <= size_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      kill_q     <= kill_d;
      lat_q      <= lat_d;
      last_lat_q <= last_lat_d;
    end
  end

  assign data_wr     = wr_q;
  assign data_size   = size_q;
  assign data_wdata  = wdata_q;
  assign mem_rdata_o = rdata_q;
  assign last_lat_o  = last_lat_q;

`ifdef DMEM_KSEG_MAP_EN
  // kseg0/kseg1 (top bits 2'b10) fold onto the low 512 MB of physical space.
  assign data_addr = (addr_q[ADDR_W-1 -: 2] == 2'b10) ? {3'b000, addr_q[ADDR_W-4:0]} : addr_q;
`else
  assign data_addr = addr_q;
`endif

endmodule

// File: tb/tb_dmem_sramlike_bridge.sv
// Scoreboard bench for dmem_sramlike_bridge: expected bus requests are queued
// when an access is issued and checked by a monitor at each accepted request.
module tb_dmem_sramlike_bridge;

  logic        clk, rst;
  logic        mem_en_i, cpu_stall_i, flush_i;
  logic [3:0]  mem_wen_i;
  logic [1:0]  mem_size_i;
  logic [31:0] mem_addr_i, mem_wdata_i, mem_rdata_o;
  logic        mem_stall_o;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [7:0]  last_lat_o;

  dmem_sramlike_bridge #(.ADDR_W(32), .LAT_CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .mem_en_i(mem_en_i), .mem_wen_i(mem_wen_i), .mem_size_i(mem_size_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o),
    .mem_stall_o(mem_stall_o), .cpu_stall_i(cpu_stall_i), .flush_i(flush_i),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_rdata(data_rdata), .data_data_ok(data_data_ok), .last_lat_o(last_lat_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  int   vecs = 0, errs = 0;
  int   req_pulses = 0, done_stall = 0, req_hole = 0;
  int   stalls, base;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Expected bus address for a given core address.
  function automatic logic [31:0] bus_addr(input logic [31:0] a);
`ifdef DMEM_KSEG_MAP_EN
    return (a[31:30] == 2'b10) ? {3'b000, a[28:0]} : a;
`else
    return a;
`endif
  endfunction

  task automatic push_exp(input logic wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    e.wr = wr; e.size = sz; e.addr = bus_addr(a); e.wdata = wd;
    exp_q.push_back(e);
  endtask

  // Monitor: counts request pulses and checks each accepted request.
  initial begin
    logic req_prev;
    exp_t e;
    req_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) req_prev = 1'b0;
      else begin
        if (data_req && !req_prev) req_pulses++;
        req_prev = data_req;
        if (data_req && data_addr_ok) begin
          if (exp_q.size() == 0) begin
            vecs++; errs++;
            $display("FAIL unexpected_req: got addr 0x%08h, expected no request", data_addr);
          end else begin
            e = exp_q.pop_front();
            chk("req_wr",    32'(data_wr),   32'(e.wr));
            chk("req_size",  32'(data_size), 32'(e.size));
            chk("req_addr",  data_addr,      e.addr);
            chk("req_wdata", data_wdata,     e.wdata);
          end
        end
      end
    end
  end

  // One access: cycle 0 is the IDLE cycle with mem_en; REQ starts at cycle 1.
  // aok/dok are counted from the first REQ cycle (dok >= aok). flush_c < 0: no flush.
  task automatic access(input logic [3:0] wen, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input int aok, input int dok, input logic [31:0] rd,
                        input int hold, input int flush_c, output int st);
    int last_c, end_c;
    last_c = 1 + dok;
    end_c  = (flush_c >= 0) ? last_c : last_c + hold + 1;
    st = 0;
    push_exp(wen != 4'd0, sz, a, wd);
    for (int c = 0; c <= end_c; c++) begin
      @(posedge clk); #1;
      mem_en_i     = (flush_c < 0) || (c < flush_c);
      flush_i      = (c == flush_c);
      mem_wen_i    = wen;
      mem_size_i   = sz;
      mem_addr_i   = a;
      mem_wdata_i  = wd;
      cpu_stall_i  = (c > last_c) && (c <= last_c + hold);
      data_addr_ok = (c == 1 + aok);
      data_data_ok = (c == last_c);
      data_rdata   = rd;
      @(negedge clk);
      if (c <= last_c) st += int'(mem_stall_o);
      else if (mem_stall_o) done_stall++;
      if (c >= 1 && c <= 1 + aok && !data_req) req_hole++;
    end
    @(posedge clk); #1;
    mem_en_i = 1'b0; flush_i = 1'b0; cpu_stall_i = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; mem_en_i = 1'b0; mem_wen_i = 4'd0; mem_size_i = 2'd0;
    mem_addr_i = '0; mem_wdata_i = '0; cpu_stall_i = 1'b0; flush_i = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;

    // Reset state
    #3;
    chk("rst_req",      32'(data_req),    0);
    chk("rst_wr",       32'(data_wr),     0);
    chk("rst_size",     32'(data_size),   0);
    chk("rst_addr",     data_addr,        0);
    chk("rst_wdata",    data_wdata,       0);
    chk("rst_rdata",    mem_rdata_o,      0);
    chk("rst_last_lat", 32'(last_lat_o),  0);
    chk("rst_stall",    32'(mem_stall_o), 0);
    @(posedge clk); #1 rst = 1'b0;
    idle_cycles(2);

    // Load word, addr_ok on REQ cycle 1, data_ok on cycle 3
    base = req_pulses;
    access(4'b0000, 2'd2, 32'h8000_0010, 32'h0, 1, 3, 32'hDEAD_BEEF, 0, -1, stalls);
    chk("lw_stall_cycles", stalls, 4);
    chk("lw_rdata",        mem_rdata_o, 32'hDEAD_BEEF);
    chk("lw_last_lat",     32'(last_lat_o), 3);
    chk("lw_req_pulses",   req_pulses - base, 1);

    // Store byte on a zero-wait bus: stalled in the issue cycle and the REQ cycle only
    base = req_pulses;
    access(4'b0100, 2'd0, 32'h0000_1002, 32'h00AB_0000, 0, 0, 32'hFFFF_FFFF, 0, -1, stalls);
    chk("sb_stall_cycles", stalls, 2);
    chk("sb_rdata_kept",   mem_rdata_o, 32'hDEAD_BEEF);
    chk("sb_last_lat",     32'(last_lat_o), 0);
    chk("sb_req_pulses",   req_pulses - base, 1);

    // Load completing while the core stays frozen 5 more cycles
    base = req_pulses; done_stall = 0;
    access(4'b0000, 2'd2, 32'h0000_0040, 32'h0, 0, 2, 32'hCAFE_F00D, 5, -1, stalls);
    chk("hold_stall_cycles", stalls, 3);
    chk("hold_done_stall",   done_stall, 0);
    chk("hold_req_pulses",   req_pulses - base, 1);
    chk("hold_rdata",        mem_rdata_o, 32'hCAFE_F00D);
    chk("hold_last_lat",     32'(last_lat_o), 2);

    // Flush while in WAIT, response arrives later
    base = req_pulses;
    access(4'b0000, 2'd2, 32'h0000_0080, 32'h0, 0, 3, 32'h1234_5678, 0, 2, stalls);
    idle_cycles(5);
    chk("flush_rdata_kept", mem_rdata_o, 32'hCAFE_F00D);
    chk("flush_req_pulses", req_pulses - base, 1);
    chk("flush_last_lat",   32'(last_lat_o), 3);

    // Flush in IDLE: no request, no stall
    base = req_pulses; stalls = 0;
    mem_en_i = 1'b1; flush_i = 1'b1; mem_addr_i = 32'h0000_0F00; mem_wen_i = 4'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      stalls += int'(mem_stall_o);
      @(posedge clk); #1;
    end
    mem_en_i = 1'b0; flush_i = 1'b0;
    idle_cycles(2);
    chk("flush_idle_stall", stalls, 0);
    chk("flush_idle_reqs",  req_pulses - base, 0);

    // addr_ok withheld 300 cycles: counter saturates, req held
    base = req_pulses; req_hole = 0;
    access(4'b0000, 2'd2, 32'h0000_0300, 32'h0, 300, 301, 32'h5555_5555, 0, -1, stalls);
    chk("sat_last_lat",     32'(last_lat_o), 255);
    chk("sat_req_hole",     req_hole, 0);
    chk("sat_req_pulses",   req_pulses - base, 1);
    chk("sat_stall_cycles", stalls, 302);
    chk("sat_rdata",        mem_rdata_o, 32'h5555_5555);

    // Reset pulsed while in WAIT
    base = req_pulses;
    push_exp(1'b0, 2'd2, 32'h0000_0100, 32'h0);
    @(posedge clk); #1;
    mem_en_i = 1'b1; mem_wen_i = 4'd0; mem_size_i = 2'd2; mem_addr_i = 32'h0000_0100;
    @(posedge clk); #1 data_addr_ok = 1'b1;
    @(posedge clk); #1 data_addr_ok = 1'b0;
    #2 rst = 1'b1; mem_en_i = 1'b0;
    #1;
    chk("midrst_req",      32'(data_req),    0);
    chk("midrst_size",     32'(data_size),   0);
    chk("midrst_addr",     data_addr,        0);
    chk("midrst_rdata",    mem_rdata_o,      0);
    chk("midrst_last_lat", 32'(last_lat_o),  0);
    chk("midrst_stall",    32'(mem_stall_o), 0);
    @(posedge clk); #1 rst = 1'b0;
    idle_cycles(5);
    chk("midrst_no_req", req_pulses - base, 1);

    // Recovery: fresh load after reset
    base = req_pulses;
    access(4'b0000, 2'd2, 32'hA000_0200, 32'h0, 0, 1, 32'hA5A5_A5A5, 0, -1, stalls);
    chk("rec_rdata",      mem_rdata_o, 32'hA5A5_A5A5);
    chk("rec_req_pulses", req_pulses - base, 1);
    chk("rec_last_lat",   32'(last_lat_o), 1);
    idle_cycles(2);
    chk("sb_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
